game_state_ctrl: RTL

- Top-level game-flow FSM. Runs once per frame_clk.
- Produces the 2-bit `state` bus that every enemy block consumes; enemies free-run only while state = 2'b01 and self-reset otherwise.
- Consumes the enemy `collides` flags, Mario's screen position and the scroll offset. From these it decides death (enemy hit or pit fall), win (flagpole), lives bookkeeping and respawn.

---
 rtl/game_state_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl -- top-level game-flow FSM, clocked once per frame.
//
// Drives the 2-bit game state consumed by the enemy blocks and decides
// death (enemy hit or pit fall), win (flagpole), lives bookkeeping and
// respawn.
//
// Optional build macro: GAME_STATE_GRACE_EN adds a post-respawn enemy
// immunity window of GRACE_FRAMES frames. Pit deaths are never masked.
//
// Ports:
//   frame_clk          in   frame-rate clock, all updates on rising edge
//   Reset              in   synchronous, active-high reset
//   start              in   start/confirm button (level, edge-detected here)
//   collides_e1/e2     in   sticky enemy collision flags
//   Ball_X_Pos [17:0]  in   Mario screen X
//   Ball_Y_Pos [17:0]  in   Mario screen Y
//   background_offset  in   scroll offset [17:0]
//   state [1:0]        out  00 TITLE, 01 PLAY, 10 DYING, 11 END
//   lives [2:0]        out  remaining lives
//   win                out  in END: 1 = flag reached, 0 = game over
//   respawn            out  one-frame pulse on the first PLAY frame
//   timer [7:0]        out  frame count in DYING/END
module game_state_ctrl #(
  parameter int unsigned INIT_LIVES      = 3,
  parameter int unsigned DEATH_FRAMES    = 120,
  parameter int unsigned END_HOLD_FRAMES = 180,
  parameter int unsigned PIT_Y           = 460,
  parameter int unsigned FLAG_X          = 12672
`ifdef GAME_STATE_GRACE_EN
  ,
  parameter int unsigned GRACE_FRAMES    = 90
`endif
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        collides_e1,
  input  logic        collides_e2,
  input  logic [17:0] Ball_X_Pos,
  input  logic [17:0] Ball_Y_Pos,
  input  logic [17:0] background_offset,
  output logic [1:0]  state,
  output logic [2:0]  lives,
  output logic        win,
  output logic        respawn,
  output logic [7:0]  timer
);

  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_END   = 2'b11
  } state_t;

  localparam logic [2:0]  LIVES_INIT    = 3'(INIT_LIVES);
  localparam logic [7:0]  DEATH_LAST    = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0]  END_HOLD_LAST = 8'(END_HOLD_FRAMES - 1);
  localparam logic [17:0] PIT_Y_L       = 18'(PIT_Y);
  localparam logic [17:0] FLAG_X_L      = 18'(FLAG_X);

  state_t      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic        win_q, win_d;
  logic        respawn_q, respawn_d;
  logic [7:0]  timer_q, timer_d;
  logic        start_prev_q, start_prev_d;
  logic        hit_prev_q, hit_prev_d;

  logic        start_rise;
  logic        hit;
  logic        hit_rise;
  logic        hit_kill;
  logic        pit;
  logic        flag;
  logic [17:0] x_global;

`ifdef GAME_STATE_GRACE_EN
  localparam int unsigned GRACE_W = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES + 1) : 1;
  logic [GRACE_W-1:0] grace_q, grace_d;
`endif

  assign start_rise = start & ~start_prev_q;
  assign hit        = collides_e1 | collides_e2;
  // Enemy flags stay high until PLAY is left, so only the rising edge kills.
  assign hit_rise   = hit & ~hit_prev_q;
  assign x_global   = Ball_X_Pos + background_offset;
  assign pit        = (Ball_Y_Pos > PIT_Y_L);
  assign flag       = (x_global >= FLAG_X_L);

`ifdef GAME_STATE_GRACE_EN
  // A hit edge swallowed during grace is lost for good: the sticky flag
  // never produces another rising edge in this PLAY stint.
  assign hit_kill = hit_rise & (grace_q == '0);
`else
  assign hit_kill = hit_rise;
`endif

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    win_d        = win_q;
    respawn_d    = 1'b0;
    timer_d      = timer_q;
    start_prev_d = start;
    hit_prev_d   = hit;

    case (state_q)
      ST_TITLE: begin
        if (start_rise) begin
          lives_d   = LIVES_INIT;
          win_d     = 1'b0;
          timer_d   = '0;
          respawn_d = 1'b1;
          state_d   = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (flag) begin
          state_d = ST_END;
          win_d   = 1'b1;
          timer_d = '0;
        end else if (hit_kill || pit) begin
          // Lives are charged once, on leaving DYING.
          state_d = ST_DYING;
          timer_d = '0;
        end
      end

      ST_DYING: begin
        if (timer_q == DEATH_LAST) begin
          timer_d = '0;
          if (lives_q <= 3'd1) begin
            lives_d = '0;
            win_d   = 1'b0;
            state_d = ST_END;
          end else begin
            lives_d   = lives_q - 3'd1;
            respawn_d = 1'b1;
            state_d   = ST_PLAY;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_END: begin
        if (start_rise && (timer_q >= END_HOLD_LAST)) begin
          state_d = ST_TITLE;
          timer_d = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_TITLE;
      end
    endcase
  end

`ifdef GAME_STATE_GRACE_EN
  always_comb begin
    grace_d = grace_q;
    if (respawn_d) begin
      grace_d = GRACE_W'(GRACE_FRAMES);
    end else if (grace_q != '0) begin
      grace_d = grace_q - GRACE_W'(1);
    end
  end
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ST_TITLE;
      lives_q      <= '0;
      win_q        <= 1'b0;
      respawn_q    <= 1'b0;
      timer_q      <= '0;
      start_prev_q <= 1'b0;
      hit_prev_q   <= 1'b0;
`ifdef GAME_STATE_GRACE_EN
      grace_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      win_q        <= win_d;
      respawn_q    <= respawn_d;
      timer_q      <= timer_d;
      start_prev_q <= start_prev_d;
      hit_prev_q   <= hit_prev_d;
`ifdef GAME_STATE_GRACE_EN
      grace_q      <= grace_d;
`endif
    end
  end

  assign state   = state_q;
  assign lives   = lives_q;
  assign win     = win_q;
  assign respawn = respawn_q;
  assign timer   = timer_q;

endmodule
